// File: rtl/axis_zmod_trigger.sv
// Edge trigger and capture window for the two-channel Zmod ADC stream.
// After arm and a holdoff, waits for a level crossing on one channel, then
// forwards a fixed-length window as one AXIS packet. Upstream cannot stall,
// so samples that find the output register full are dropped and flagged.
module axis_zmod_trigger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        arm,
    input  logic                        force_trig,
    input  logic                        cfg_chan,
    input  logic                        cfg_edge,
    input  logic [15:0]                 cfg_level,
    input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [2:0]                  sts_state,
    output logic                        sts_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Configuration latched on arm so it cannot change mid-acquisition.
    logic                   chan_q;
    logic                   edge_q;
    logic signed [15:0]     level_q;
    logic [CNTR_WIDTH-1:0]  holdoff_q;
    logic [CNTR_WIDTH-1:0]  length_q;

    logic [CNTR_WIDTH-1:0]  hold_cnt;
    logic [CNTR_WIDTH-1:0]  cap_cnt;
    logic signed [15:0]     prev;
    logic                   prev_valid;

    logic signed [15:0]     x;
    logic [CNTR_WIDTH-1:0]  last_idx;
    logic [CNTR_WIDTH-1:0]  idx;
    logic                   crossed;
    logic                   trig;
    logic                   offer;
    logic                   can_load;

    // Trigger detection and capture-offer decode for the current cycle.
    always_comb begin
        x        = chan_q ? s_axis_tdata[31:16] : s_axis_tdata[15:0];
        // A zero length behaves as a single-sample capture.
        last_idx = (length_q == '0) ? '0 : length_q - CNTR_WIDTH'(1);
        crossed  = edge_q ? (prev > level_q && x <= level_q)
                          : (prev < level_q && x >= level_q);
        trig     = s_axis_tvalid && state == ST_WAIT
                   && (force_trig || (prev_valid && crossed));
        // arm wins over any capture activity in the same cycle.
        offer    = !arm && (trig || (s_axis_tvalid && state == ST_CAPTURE));
        idx      = (state == ST_WAIT) ? '0 : cap_cnt;
        // Output register is free if empty or being drained this cycle.
        can_load = !m_axis_tvalid || m_axis_tready;
    end

    // Next-state decode; idle cycles on the input never move the FSM.
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = (cfg_holdoff != '0) ? ST_ARMED : ST_WAIT;
        end else if (s_axis_tvalid) begin
            case (state)
                ST_ARMED:
                    if (hold_cnt + CNTR_WIDTH'(1) == holdoff_q) state_nxt = ST_WAIT;
                ST_WAIT:
                    if (trig) state_nxt = (last_idx == '0) ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE:
                    if (cap_cnt == last_idx) state_nxt = ST_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Config latch, counters, previous-sample tracking and output register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            chan_q        <= 1'b0;
            edge_q        <= 1'b0;
            level_q       <= '0;
            holdoff_q     <= '0;
            length_q      <= '0;
            hold_cnt      <= '0;
            cap_cnt       <= '0;
            prev          <= '0;
            prev_valid    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            sts_overrun   <= 1'b0;
        end else begin
            if (offer && can_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= (idx == last_idx);
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (offer && !can_load) sts_overrun <= 1'b1;

            if (arm) begin
                chan_q      <= cfg_chan;
                edge_q      <= cfg_edge;
                level_q     <= cfg_level;
                holdoff_q   <= cfg_holdoff;
                length_q    <= cfg_length;
                hold_cnt    <= '0;
                cap_cnt     <= '0;
                prev_valid  <= 1'b0;
                sts_overrun <= 1'b0;
            end else if (s_axis_tvalid) begin
                case (state)
                    ST_ARMED: hold_cnt <= hold_cnt + CNTR_WIDTH'(1);
                    ST_WAIT: begin
                        if (trig) begin
                            cap_cnt <= CNTR_WIDTH'(1);
                        end else begin
                            prev       <= x;
                            prev_valid <= 1'b1;
                        end
                    end
                    ST_CAPTURE: cap_cnt <= cap_cnt + CNTR_WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

    assign sts_state = state;

endmodule

// File: tb/tb_axis_zmod_trigger.sv
// Self-checking bench for axis_zmod_trigger: a cycle vector table for the
// rising-edge case, hand sequences for multi-cycle corners, and random
// acquisitions checked against a packet-level reference model.
module tb_axis_zmod_trigger;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arm, force_trig, cfg_chan, cfg_edge;
    logic [15:0] cfg_level, cfg_holdoff, cfg_length;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [2:0]  sts_state;
    logic        sts_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] beats[$];   // {tlast, tdata} of every accepted beat

    always #5 aclk = ~aclk;

    axis_zmod_trigger #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16)) dut (
        .aclk(aclk), .areset(areset), .arm(arm), .force_trig(force_trig),
        .cfg_chan(cfg_chan), .cfg_edge(cfg_edge), .cfg_level(cfg_level),
        .cfg_holdoff(cfg_holdoff), .cfg_length(cfg_length),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .sts_state(sts_state), .sts_overrun(sts_overrun)
    );

    // Record handshakes mid-cycle, where inputs and outputs are stable.
    always @(negedge aclk)
        if (!areset && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tlast, m_axis_tdata});

    typedef struct {
        logic        arm, vld, frc;
        logic [31:0] d;
        logic        e_tv;
        logic [31:0] e_data;
        logic        e_last;
        logic [2:0]  e_state;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic a, logic v, logic f, logic [31:0] d,
                                logic etv, logic [31:0] ed, logic el, logic [2:0] es);
        vec_t r;
        r.arm = a; r.vld = v; r.frc = f; r.d = d;
        r.e_tv = etv; r.e_data = ed; r.e_last = el; r.e_state = es;
        return r;
    endfunction

    function automatic logic [31:0] dA(int a);
        return {16'h1234, 16'(a)};
    endfunction

    function automatic int chv(logic [31:0] d, logic ch);
        logic signed [15:0] s;
        s = ch ? d[31:16] : d[15:0];
        return int'(s);
    endfunction

    task automatic check(string name, logic [32:0] act, logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_beat(string name, int i, logic [32:0] exp);
        n_checks++;
        if (i >= beats.size()) begin
            n_fail++;
            $display("FAIL %s: beat %0d missing, expected %0h", name, i, exp);
        end else if (beats[i] !== exp) begin
            n_fail++;
            $display("FAIL %s: beat %0d got %0h expected %0h", name, i, beats[i], exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic set_cfg(logic ch, logic ed, int lvl, int ho, int ln);
        cfg_chan = ch; cfg_edge = ed; cfg_level = 16'(lvl);
        cfg_holdoff = 16'(ho); cfg_length = 16'(ln);
    endtask

    task automatic do_arm();
        arm = 1'b1; s_axis_tvalid = 1'b0; tick(); arm = 1'b0;
    endtask

    task automatic send(logic [31:0] d, logic f);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; force_trig = f;
        tick();
        s_axis_tvalid = 1'b0; force_trig = 1'b0;
    endtask

    task automatic idle(int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] samp[$];
        logic [32:0] expq[$];
        logic [15:0] b;
        int t, hold, len_eff, n, lvl, p, x;
        logic ch, ed;

        areset = 1'b1; arm = 0; force_trig = 0; s_axis_tvalid = 0;
        s_axis_tdata = '0; m_axis_tready = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        #22;
        check("rst_tvalid",  33'(m_axis_tvalid), 33'd0);
        check("rst_tlast",   33'(m_axis_tlast),  33'd0);
        check("rst_tdata",   33'(m_axis_tdata),  33'd0);
        check("rst_state",   33'(sts_state),     33'd0);
        check("rst_overrun", 33'(sts_overrun),   33'd0);
        areset = 1'b0;
        tick();
        check("idle_hold", 33'(sts_state), 33'd0);

        // Rising crossing on channel A at level 100, length 4.
        vecs[0]  = mk(1, 0, 0, 32'd0,   0, 0,        0, 3'd2);
        vecs[1]  = mk(0, 1, 0, dA(90),  0, 0,        0, 3'd2);
        vecs[2]  = mk(0, 1, 0, dA(95),  0, 0,        0, 3'd2);
        vecs[3]  = mk(0, 1, 0, dA(99),  0, 0,        0, 3'd2);
        vecs[4]  = mk(0, 1, 0, dA(100), 1, dA(100),  0, 3'd3);
        vecs[5]  = mk(0, 1, 0, dA(101), 1, dA(101),  0, 3'd3);
        vecs[6]  = mk(0, 0, 0, dA(7),   0, 0,        0, 3'd3);
        vecs[7]  = mk(0, 1, 0, dA(102), 1, dA(102),  0, 3'd3);
        vecs[8]  = mk(0, 1, 0, dA(103), 1, dA(103),  1, 3'd4);
        vecs[9]  = mk(0, 1, 0, dA(104), 0, 0,        0, 3'd4);
        vecs[10] = mk(0, 1, 1, dA(50),  0, 0,        0, 3'd4);
        set_cfg(0, 0, 100, 0, 4);
        for (int i = 0; i < 11; i++) begin
            arm = vecs[i].arm; s_axis_tvalid = vecs[i].vld;
            force_trig = vecs[i].frc; s_axis_tdata = vecs[i].d;
            tick();
            check($sformatf("vec%0d_state", i), 33'(sts_state), 33'(vecs[i].e_state));
            check($sformatf("vec%0d_tvalid", i), 33'(m_axis_tvalid), 33'(vecs[i].e_tv));
            if (vecs[i].e_tv) begin
                check($sformatf("vec%0d_tdata", i), 33'(m_axis_tdata), 33'(vecs[i].e_data));
                check($sformatf("vec%0d_tlast", i), 33'(m_axis_tlast), 33'(vecs[i].e_last));
            end
        end
        arm = 0; force_trig = 0; s_axis_tvalid = 0;
        idle(2);

        // Falling on chB, holdoff 3; the crossing inside holdoff is ignored.
        beats.delete();
        set_cfg(1, 1, -50, 3, 2);
        do_arm();
        check("fall_armed", 33'(sts_state), 33'd1);
        for (int k = 0; k < 10; k++) begin
            b = (k % 2 == 1) ? 16'hFFC4 : 16'h0000;
            send({b, 16'(k)}, 1'b0);
        end
        idle(3);
        check("fall_count", 33'(beats.size()), 33'd2);
        check_beat("fall_b0", 0, {1'b0, 16'hFFC4, 16'd5});
        check_beat("fall_b1", 1, {1'b1, 16'h0000, 16'd6});
        check("fall_state", 33'(sts_state), 33'd4);

        // Overrun: ready low across the trigger cycle and the next two.
        beats.delete();
        set_cfg(0, 0, 0, 0, 6);
        do_arm();
        m_axis_tready = 1'b0;
        send(32'hA000_0000, 1'b1);
        send(32'hA000_0001, 1'b0);
        send(32'hA000_0002, 1'b0);
        m_axis_tready = 1'b1;
        for (int k = 3; k < 6; k++) send(32'hA000_0000 + 32'(k), 1'b0);
        idle(3);
        check("ovr_count", 33'(beats.size()), 33'd4);
        check_beat("ovr_b0", 0, {1'b0, 32'hA000_0000});
        check_beat("ovr_b1", 1, {1'b0, 32'hA000_0003});
        check_beat("ovr_b2", 2, {1'b0, 32'hA000_0004});
        check_beat("ovr_b3", 3, {1'b1, 32'hA000_0005});
        check("ovr_flag", 33'(sts_overrun), 33'd1);
        check("ovr_state", 33'(sts_state), 33'd4);
        do_arm();
        check("ovr_cleared", 33'(sts_overrun), 33'd0);

        // Force trigger with length 0 gives one beat with tlast.
        beats.delete();
        set_cfg(0, 0, 100, 0, 0);
        do_arm();
        send(32'h0000_0005, 1'b1);
        check("frc_state", 33'(sts_state), 33'd4);
        send(32'h0000_0200, 1'b0);
        send(32'h0000_0300, 1'b1);
        idle(2);
        check("frc_count", 33'(beats.size()), 33'd1);
        check_beat("frc_b0", 0, {1'b1, 32'h0000_0005});

        // Gaps do not count; arm mid-capture keeps the pending beat.
        beats.delete();
        set_cfg(0, 0, 0, 2, 3);
        do_arm();
        check("gap_armed0", 33'(sts_state), 33'd1);
        send(32'hB000_0000, 1'b0);
        check("gap_armed1", 33'(sts_state), 33'd1);
        idle(1);
        check("gap_armed2", 33'(sts_state), 33'd1);
        send(32'hB000_0001, 1'b0);
        check("gap_wait", 33'(sts_state), 33'd2);
        idle(1);
        m_axis_tready = 1'b0;
        send(32'hB000_0002, 1'b1);
        check("gap_capture", 33'(sts_state), 33'd3);
        do_arm();
        check("rearm_state", 33'(sts_state), 33'd1);
        check("rearm_tvalid", 33'(m_axis_tvalid), 33'd1);
        check("rearm_tdata", 33'(m_axis_tdata), 33'hB000_0002);
        m_axis_tready = 1'b1;
        idle(2);
        check("rearm_count", 33'(beats.size()), 33'd1);
        check_beat("rearm_b0", 0, {1'b0, 32'hB000_0002});
        check("rearm_drained", 33'(m_axis_tvalid), 33'd0);

        // Asynchronous reset in the middle of a capture.
        set_cfg(0, 0, 0, 0, 8);
        do_arm();
        send(32'hC000_0000, 1'b1);
        send(32'hC000_0001, 1'b0);
        check("ares_pre", 33'(m_axis_tvalid), 33'd1);
        #1 areset = 1'b1;
        #1;
        check("ares_tvalid", 33'(m_axis_tvalid), 33'd0);
        check("ares_tlast",  33'(m_axis_tlast),  33'd0);
        check("ares_state",  33'(sts_state),     33'd0);
        check("ares_tdata",  33'(m_axis_tdata),  33'd0);
        #3 areset = 1'b0;
        tick();

        // Random acquisitions against a packet-level model (ready held high).
        m_axis_tready = 1'b1;
        for (int tr = 0; tr < 30; tr++) begin
            ch = 1'($urandom_range(0, 1));
            ed = 1'($urandom_range(0, 1));
            lvl = int'($urandom_range(0, 200)) - 100;
            hold = int'($urandom_range(0, 5));
            n = int'($urandom_range(0, 8));
            set_cfg(ch, ed, lvl, hold, n);
            len_eff = (n == 0) ? 1 : n;
            beats.delete(); samp.delete(); expq.delete();
            do_arm();
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                else begin
                    s_axis_tdata = {16'(lvl + int'($urandom_range(0, 40)) - 20),
                                    16'(lvl + int'($urandom_range(0, 40)) - 20)};
                    samp.push_back(s_axis_tdata);
                    send(s_axis_tdata, 1'b0);
                end
            end
            idle(3);
            // First crossing among samples after the holdoff; the first such
            // sample only primes prev.
            t = -1;
            for (int j = hold + 1; j < samp.size() && t < 0; j++) begin
                p = chv(samp[j-1], ch);
                x = chv(samp[j], ch);
                if (ed ? (p > lvl && x <= lvl) : (p < lvl && x >= lvl)) t = j;
            end
            if (t >= 0)
                for (int j = t; j < t + len_eff && j < samp.size(); j++)
                    expq.push_back({(j == t + len_eff - 1), samp[j]});
            check($sformatf("rnd%0d_count", tr), 33'(beats.size()), 33'(expq.size()));
            foreach (expq[i]) check_beat($sformatf("rnd%0d", tr), i, expq[i]);
            check($sformatf("rnd%0d_overrun", tr), 33'(sts_overrun), 33'd0);
            if (t >= 0 && t + len_eff <= samp.size())
                check($sformatf("rnd%0d_state", tr), 33'(sts_state), 33'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
